// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- iterative multiply/divide unit with HI/LO registers.
//
// Executes MULT/MULTU/DIV/DIVU over 32 CALC iterations plus one FIX cycle.
// Multiply is radix-2 shift-add and divide is restoring division. Both work on
// operand magnitudes, and FIX applies the result signs. The unit also serves
// MTHI/MTLO writes while idle.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset, clears all state
//   start  in   launch the operation selected by op (ignored while busy)
//   op     in   0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU
//   a      in   rs operand (also the MTHI/MTLO source)
//   b      in   rt operand
//   mthi   in   write a into HI (idle only, start has priority)
//   mtlo   in   write a into LO (idle only, start has priority)
//   busy   out  high in CALC and FIX
//   done   out  one-cycle pulse when new HI/LO values first become visible
//   hi     out  HI register
//   lo     out  LO register
// -----------------------------------------------------------------------------
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;          // original dividend, for divide-by-zero HI
  logic [WIDTH-1:0]   mcand_q, mcand_d;  // |b|: multiplicand or divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;      // mul: {partial, multiplier}; div: {rem, quotient}
  logic               neg_q, neg_d;      // product/quotient must be negated
  logic               rneg_q, rneg_d;    // remainder must be negated (dividend sign)
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Start-cycle operand conditioning
  logic             op_signed;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_signed = ~op[0];
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

  // One shift-add multiply step: add the multiplicand into the upper half when
  // the multiplier LSB is set, then shift the whole accumulator right. The
  // carry out of the add becomes the new MSB.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor. A non-negative difference sets the
  // quotient bit and is kept; otherwise the shifted remainder is restored.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_qbit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign div_qbit  = ~div_diff[WIDTH];
  assign div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_qbit};

  // Sign fix-up of the finished magnitudes
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_q  ? -acc_q : acc_q;
  assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          mcand_d = b_mag;
          acc_d   = {{WIDTH{1'b0}}, a_mag};
          neg_d   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = op_signed & a[WIDTH-1];
          cnt_d   = '0;
          state_d = S_CALC;
        end else begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end

      S_CALC: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end

      S_FIX: begin
        if (!op_q[1]) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (mcand_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit -- directed, table-driven bench for md_unit.
// -----------------------------------------------------------------------------
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench model of the architectural HI/LO contents
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    bit          mt;   // also assert mthi/mtlo in the start cycle
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Launch one operation, watch 36 cycles, and compare timing and results.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit disturb, input bit mt_with_start);
    int busy_n, done_n, done_at, held_bad;
    logic [31:0] got_hi, got_lo;
    busy_n = 0; done_n = 0; done_at = 0; held_bad = 0;
    got_hi = '0; got_lo = '0;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    mthi = mt_with_start; mtlo = mt_with_start;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = ~av; b = ~bv;   // operands must already be captured
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = k;
        got_hi  = hi;
        got_lo  = lo;
      end
      if (k <= 33 && (hi !== m_hi || lo !== m_lo)) held_bad++;
      if (disturb && k >= 5 && k <= 7) begin
        start = 1'b1; op = 2'd3; mthi = 1'b1; mtlo = 1'b1; a = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("busy_cycles", busy_n, 33);
    check("done_pulses", done_n, 1);
    check("done_cycle", done_at, 34);
    check("hilo_held", held_bad, 0);
    check("hi_result", got_hi, eh);
    check("lo_result", got_lo, el);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h)", o, av, bv, got_hi, got_lo, eh, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int done_seen;

    vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{2'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0};
    vecs[7]  = '{2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b1};
    vecs[8]  = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{2'd1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[10] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, 1'b0, vecs[i].mt);

    // Requests during busy must be ignored
    run_op(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1, 1'b0);

    // MTHI and MTLO together in idle
    @(negedge clk);
    a = 32'h1234_5678; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk);
    #1;
    mthi = 1'b0; mtlo = 1'b0; a = '0;
    @(negedge clk);
    check("mt_both_hi", hi, 32'h1234_5678);
    check("mt_both_lo", lo, 32'h1234_5678);
    $display("mthi+mtlo a=12345678 -> hi=%h lo=%h", hi, lo);
    m_hi = 32'h1234_5678; m_lo = 32'h1234_5678;

    // MTHI alone leaves LO untouched
    a = 32'hAAAA_5555; mthi = 1'b1;
    @(posedge clk);
    #1;
    mthi = 1'b0; a = '0;
    @(negedge clk);
    check("mthi_hi", hi, 32'hAAAA_5555);
    check("mthi_lo", lo, m_lo);
    $display("mthi a=aaaa5555 -> hi=%h lo=%h", hi, lo);
    m_hi = 32'hAAAA_5555;

    // Reset in the middle of a DIV
    @(negedge clk);
    op = 2'd2; a = 32'd64; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_seen = 0;
    repeat (9) @(negedge clk);
    check("mid_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    $display("reset mid-DIV -> busy=%0d hi=%h lo=%h", busy, hi, lo);
    m_hi = '0; m_lo = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 0);

    run_op(2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
